// File: rtl/scan_sel_sequencer_pkg.sv
// Shared constants for the scan-select decoder family: channel count and
// sequencer state encodings.
package scan_sel_sequencer_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/scan_sel_sequencer_next_channel_finder.sv
// Combinational circular search for the next enabled channel strictly above
// cur (7 wraps to 0). Flags wrap when the result is not above cur.
module next_channel_finder
  import scan_sel_sequencer_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   nxt,
  output logic              wrap
);

  logic [CH_W-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    nxt = cur;
    idx = cur;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = cur + CH_W'(k);
      if (mask[idx]) nxt = idx;
    end
    wrap = (nxt <= cur);
  end

endmodule

// File: rtl/scan_sel_sequencer.sv
// Channel scan sequencer: dwells dwell+1 cycles on each enabled channel and
// drives a registered 3-bit select for a downstream 3-to-8 decoder.
module scan_sel_sequencer
  import scan_sel_sequencer_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [CH_W-1:0]    sel,
  output logic               sel_valid,
  output logic               step,
  output logic               frame_done,
  output state_t             dbg_state
);

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [CH_W-1:0]    cur;
  logic [CH_W-1:0]    nxt;
  logic               wrap;
  logic               go;

  // From IDLE, searching above the top channel yields the lowest set bit.
  assign cur = (state == ST_SCAN) ? sel : CH_W'(NUM_CH - 1);
  assign go  = en && (mask != '0);

  next_channel_finder u_finder (
    .mask (mask),
    .cur  (cur),
    .nxt  (nxt),
    .wrap (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel        <= '0;
      sel_valid  <= 1'b0;
      step       <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          step       <= 1'b0;
          frame_done <= 1'b0;
          cnt        <= '0;
          if (go) begin
            state     <= ST_SCAN;
            sel       <= nxt;
            sel_valid <= 1'b1;
          end else begin
            sel       <= '0;
            sel_valid <= 1'b0;
          end
        end
        ST_SCAN: begin
          // Dropping en or mask wins over a terminal count.
          if (!go) begin
            state      <= ST_IDLE;
            sel        <= '0;
            sel_valid  <= 1'b0;
            step       <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= '0;
          end else if (cnt >= dwell) begin
            sel        <= nxt;
            step       <= 1'b1;
            frame_done <= wrap;
            cnt        <= '0;
          end else begin
            step       <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= cnt + DWELL_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          sel       <= '0;
          sel_valid <= 1'b0;
          step      <= 1'b0;
          frame_done <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/scan_sel_sequencer.md
SCAN_SEL_SEQUENCER -- requirements
Module: scan_sel_sequencer

Interface
REQ-001 SHALL have parameter DWELL_W, default 8, width of the dwell count.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port en, input, 1, scan enable.
REQ-005 SHALL have port mask, input, 8, per-channel enable; bit i allows channel i.
REQ-006 SHALL have port dwell, input, DWELL_W, cycles per channel minus one.
REQ-007 SHALL have port sel, output, 3, registered channel index that drives the downstream 3-to-8 decoder select.
REQ-008 SHALL have port sel_valid, output, 1, high while sel is a live channel.
REQ-009 SHALL have port step, output, 1, one-cycle pulse on the cycle sel takes a new value in SCAN.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse when the scan wraps back to a lower or equal index.

Function
REQ-011 SHALL implement two states: IDLE and SCAN; all outputs registered.
REQ-012 IDLE -> SCAN SHALL occur when en=1 and mask!=0; on the next cycle sel = lowest set mask bit, sel_valid=1, dwell counter=0, step=0, frame_done=0.
REQ-013 In SCAN the dwell counter SHALL increment by 1 per cycle; terminal when counter >= dwell, compared against the live dwell input.
REQ-014 On terminal, the next cycle SHALL load sel with the next set mask bit strictly above sel, circular search (7 wraps to 0), reset the counter to 0, and pulse step=1.
REQ-015 frame_done SHALL pulse in the same cycle as step whenever the new sel <= old sel (wrap, or single-bit mask).
REQ-016 A single-bit mask SHALL keep sel constant, with step=1 and frame_done=1 every dwell+1 cycles.
REQ-017 dwell=0 SHALL advance sel every cycle, step high continuously.
REQ-018 Each channel SHALL be held for exactly dwell+1 cycles when dwell is stable.
REQ-019 Mask changes mid-dwell SHALL not cut the current slot short; the next-channel search SHALL use mask as sampled on the terminal cycle.
REQ-020 SCAN -> IDLE SHALL occur when en=0 or mask=0; the next cycle sel=0, sel_valid=0, counter=0, step=0, frame_done=0; this check SHALL take priority over terminal.
REQ-021 A dwell reduced below the current count SHALL terminate on the next cycle, with no counter wrap.
REQ-022 The counter SHALL be DWELL_W bits and SHALL never overflow (reset on terminal).

Reset
REQ-023 rst=1 SHALL immediately force IDLE, sel=0, sel_valid=0, step=0, frame_done=0, counter=0, regardless of clk.
REQ-024 Reset asserted mid-slot SHALL discard the scan position; after release, the scan SHALL restart from the lowest set mask bit per REQ-012.

Structure
REQ-025 The state encodings (IDLE=0, SCAN=1) and the channel count 8 SHALL live in a shared constants include file used by the decoder family.
REQ-026 The circular next-set-bit search SHALL be a combinational sub-module named next_channel_finder (inputs mask[7:0], cur[2:0]; outputs nxt[2:0], wrap).

Verification
REQ-027 Reset, then en=1, mask=8'hFF, dwell=2 -> sel runs 0,1,...,7,0 with 3 cycles each; step on every change; frame_done only on the 7->0 transition.
REQ-028 mask=8'b1010_0100, dwell=0 -> sel runs 2,5,7,2,... changing every cycle; frame_done on each 7->2.
REQ-029 mask=8'h10, dwell=3 -> sel stays 4; step=frame_done=1 every 4th cycle.
REQ-030 Mid-slot at sel=3, drop en -> next cycle sel=0 and sel_valid=0; re-assert en with mask=8'h08 -> sel=3, sel_valid=1.
REQ-031 Async rst pulse between clock edges during SCAN -> outputs reach reset values before the next edge; after release, restart at the lowest set mask bit.
REQ-032 At dwell=10 with counter=7, change dwell to 4 -> advance on the next cycle; change mask to 0 -> IDLE the next cycle.
